// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and defaults for the hazard/sequencing controller
package hazard_ctrl_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF = 6;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
  typedef struct packed {
    logic hold_pc;
    logic hold_if_id;
    logic hold_id_ex;
    logic flush_id_ex;
  } hz_ctrl_t;
  // all-zero encoding: pipe advances, ID/EX takes no bubble
  localparam hz_ctrl_t HZ_NONE = '0;
  // hazard: freeze PC and IF/ID, insert a bubble into ID/EX
  localparam hz_ctrl_t HZ_STALL = '{hold_pc: 1'b1, hold_if_id: 1'b1, hold_id_ex: 1'b0, flush_id_ex: 1'b1};
  // memory not ready: freeze the whole front end, no bubble
  localparam hz_ctrl_t HZ_FREEZE = '{hold_pc: 1'b1, hold_if_id: 1'b1, hold_id_ex: 1'b1, flush_id_ex: 1'b0};
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard information in, pipeline hold/flush and mult/div status out
//   master: pipeline side (drives operand/destination info, receives controls)
//   slave : hazard_ctrl side
interface hazard_ctrl_if #(parameter int ADDR_W = hazard_ctrl_pkg::ADDR_W_DEF);
  logic [ADDR_W-1:0] raddr_1_ID;
  logic [ADDR_W-1:0] raddr_2_ID;
  logic uses_rs_ID;
  logic uses_rt_ID;
  logic ReadMem_EX;
  logic [ADDR_W-1:0] waddr_EX;
  logic md_start_ID;
  logic md_is_div_ID;
  logic hilo_read_ID;
  logic mem_stall;
  logic hold_PC;
  logic hold_IF_ID;
  logic hold_ID_EX;
  logic flush_ID_EX;
  logic md_busy;
  logic md_done;
  modport master (
    output raddr_1_ID, raddr_2_ID, uses_rs_ID, uses_rt_ID, ReadMem_EX, waddr_EX,
    output md_start_ID, md_is_div_ID, hilo_read_ID, mem_stall,
    input hold_PC, hold_IF_ID, hold_ID_EX, flush_ID_EX, md_busy, md_done
  );
  modport slave (
    input raddr_1_ID, raddr_2_ID, uses_rs_ID, uses_rt_ID, ReadMem_EX, waddr_EX,
    input md_start_ID, md_is_div_ID, hilo_read_ID, mem_stall,
    output hold_PC, hold_IF_ID, hold_ID_EX, flush_ID_EX, md_busy, md_done
  );
endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// md_timer: mult/div occupancy FSM with a loadable down-counter
//   clk, rst (async, active-low); load/load_val start an operation of load_val+1 cycles;
//   busy high while running, done high in the last busy cycle
module md_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done
);
  md_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // counting continues through memory stalls; decrement stops at zero so cnt never wraps
  always_comb begin
    state_d = state_q == MD_IDLE ? (load ? MD_BUSY : MD_IDLE) : (cnt_q == '0 ? MD_IDLE : MD_BUSY);
    cnt_d = state_q == MD_IDLE ? (load ? load_val : cnt_q) : (cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy = state_q == MD_BUSY;
  assign done = busy && cnt_q == '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use and HI/LO hazard detection driving PC, IF/ID and ID/EX hold/flush
//   clk, rst (async, active-low); hz: hazard_ctrl_if.slave carrying ID/EX operand info,
//   mem_stall, mult/div requests in and hold_PC/hold_IF_ID/hold_ID_EX/flush_ID_EX/md_busy/md_done out
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave hz
);
  logic [ADDR_W-1:0] waddr;
  logic lu, mdh, stall, load, busy, done;
  logic [CNT_W-1:0] load_val;
  hz_ctrl_t ctrl;
  always_comb begin
    waddr = hz.waddr_EX;
    // r0 is never a real destination, so a load into it cannot create a dependency
    lu = hz.ReadMem_EX && waddr != '0 &&
         ((hz.uses_rs_ID && hz.raddr_1_ID == waddr) || (hz.uses_rt_ID && hz.raddr_2_ID == waddr));
    mdh = busy && (hz.hilo_read_ID || hz.md_start_ID);
    stall = lu || mdh;
    load = hz.md_start_ID && !stall && !hz.mem_stall;
    load_val = hz.md_is_div_ID ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
    // a frozen pipe must not also take a bubble, so mem_stall wins over stall
    ctrl = !rst ? HZ_NONE : hz.mem_stall ? HZ_FREEZE : stall ? HZ_STALL : HZ_NONE;
  end
  md_timer #(.CNT_W(CNT_W)) u_md_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .busy(busy),
    .done(done)
  );
  assign hz.hold_PC = ctrl.hold_pc;
  assign hz.hold_IF_ID = ctrl.hold_if_id;
  assign hz.hold_ID_EX = ctrl.hold_id_ex;
  assign hz.flush_ID_EX = ctrl.flush_id_ex;
  assign hz.md_busy = busy;
  assign hz.md_done = done;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int MUL_N = 4;
  localparam int DIV_N = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int rem = 0;
  hazard_ctrl_if #(.ADDR_W(5)) bus ();
  hazard_ctrl #(.ADDR_W(5), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .hz(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", n, $time, got, exp);
    end
  endtask
  task automatic idle_in();
    bus.raddr_1_ID = '0;
    bus.raddr_2_ID = '0;
    bus.uses_rs_ID = 1'b0;
    bus.uses_rt_ID = 1'b0;
    bus.ReadMem_EX = 1'b0;
    bus.waddr_EX = '0;
    bus.md_start_ID = 1'b0;
    bus.md_is_div_ID = 1'b0;
    bus.hilo_read_ID = 1'b0;
    bus.mem_stall = 1'b0;
  endtask
  task automatic lu_in(input logic [4:0] ra1, input logic [4:0] wa, input logic urs);
    bus.ReadMem_EX = 1'b1;
    bus.raddr_1_ID = ra1;
    bus.waddr_EX = wa;
    bus.uses_rs_ID = urs;
  endtask
  // Model: rem = busy cycles still to run including the current one (0 = idle).
  // Compare at negedge, advance the model at the following posedge; returns at posedge+1.
  task automatic cycle();
    logic lu, busy, done, stall, ms;
    @(negedge clk);
    busy = rem > 0;
    done = rem == 1;
    lu = bus.ReadMem_EX && bus.waddr_EX != 0 &&
         ((bus.uses_rs_ID && bus.raddr_1_ID == bus.waddr_EX) ||
          (bus.uses_rt_ID && bus.raddr_2_ID == bus.waddr_EX));
    stall = lu || (busy && (bus.hilo_read_ID || bus.md_start_ID));
    ms = bus.mem_stall;
    chk("hold_PC", bus.hold_PC, rst && (ms || stall));
    chk("hold_IF_ID", bus.hold_IF_ID, rst && (ms || stall));
    chk("hold_ID_EX", bus.hold_ID_EX, rst && ms);
    chk("flush_ID_EX", bus.flush_ID_EX, rst && !ms && stall);
    chk("md_busy", bus.md_busy, rst && busy);
    chk("md_done", bus.md_done, rst && done);
    @(posedge clk);
    if (!rst) rem = 0;
    else if (rem > 0) rem--;
    else if (bus.md_start_ID && !stall && !ms) rem = bus.md_is_div_ID ? DIV_N : MUL_N;
    #1;
  endtask
  initial begin
    idle_in();
    #2;
    chk("reset_hold_PC", bus.hold_PC, 1'b0);
    chk("reset_md_busy", bus.md_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // load-use hit, then r0 destination and unused rs do not stall
    lu_in(5'd8, 5'd8, 1'b1);
    #1;
    chk("lu_hit_hold_PC", bus.hold_PC, 1'b1);
    chk("lu_hit_flush", bus.flush_ID_EX, 1'b1);
    chk("lu_hit_hold_ID_EX", bus.hold_ID_EX, 1'b0);
    cycle();
    lu_in(5'd0, 5'd0, 1'b1);
    #1;
    chk("lu_r0_flush", bus.flush_ID_EX, 1'b0);
    cycle();
    lu_in(5'd8, 5'd8, 1'b0);
    #1;
    chk("lu_nors_hold_PC", bus.hold_PC, 1'b0);
    cycle();
    idle_in();
    cycle();
    // multiply then mflo
    bus.md_start_ID = 1'b1;
    #1;
    chk("mul_accept_hold_PC", bus.hold_PC, 1'b0);
    cycle();
    for (int k = 1; k <= 5; k++) begin
      idle_in();
      bus.hilo_read_ID = 1'b1;
      #1;
      chk($sformatf("mul_busy_c%0d", k), bus.md_busy, k <= 4);
      chk($sformatf("mul_done_c%0d", k), bus.md_done, k == 4);
      chk($sformatf("mflo_stall_c%0d", k), bus.hold_PC, k <= 4);
      cycle();
    end
    // back-to-back divide, second presented in the done cycle
    idle_in();
    bus.md_start_ID = 1'b1;
    bus.md_is_div_ID = 1'b1;
    cycle();
    for (int k = 1; k <= 66; k++) begin
      idle_in();
      bus.md_is_div_ID = 1'b1;
      bus.md_start_ID = k == 32 || k == 33;
      #1;
      if (k == 32) begin
        chk("div_done_c32", bus.md_done, 1'b1);
        chk("div2_stall_c32", bus.flush_ID_EX, 1'b1);
      end
      if (k == 33) chk("div2_accept_c33", bus.hold_PC, 1'b0);
      if (k == 34 || k == 65) chk($sformatf("div2_busy_c%0d", k), bus.md_busy, 1'b1);
      if (k == 65) chk("div2_done_c65", bus.md_done, 1'b1);
      if (k == 66) chk("div2_idle_c66", bus.md_busy, 1'b0);
      cycle();
    end
    // memory stall overrides load-use; divide still completes during the freeze
    idle_in();
    bus.md_start_ID = 1'b1;
    bus.md_is_div_ID = 1'b1;
    cycle();
    for (int k = 1; k <= 34; k++) begin
      idle_in();
      lu_in(5'd8, 5'd8, 1'b1);
      bus.mem_stall = k <= 33;
      #1;
      if (k == 1) begin
        chk("ms_hold_ID_EX", bus.hold_ID_EX, 1'b1);
        chk("ms_flush", bus.flush_ID_EX, 1'b0);
        chk("ms_hold_PC", bus.hold_PC, 1'b1);
      end
      if (k == 32) chk("ms_div_done_c32", bus.md_done, 1'b1);
      if (k == 33) chk("ms_div_idle_c33", bus.md_busy, 1'b0);
      if (k == 34) chk("ms_off_lu_flush", bus.flush_ID_EX, 1'b1);
      cycle();
    end
    // reset in the middle of a divide
    idle_in();
    bus.md_start_ID = 1'b1;
    bus.md_is_div_ID = 1'b1;
    cycle();
    for (int k = 1; k <= 9; k++) begin
      idle_in();
      cycle();
    end
    lu_in(5'd8, 5'd8, 1'b1);
    bus.hilo_read_ID = 1'b1;
    #1;
    chk("pre_rst_busy", bus.md_busy, 1'b1);
    chk("pre_rst_hold_PC", bus.hold_PC, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_hold_PC", bus.hold_PC, 1'b0);
    chk("rst_hold_IF_ID", bus.hold_IF_ID, 1'b0);
    chk("rst_hold_ID_EX", bus.hold_ID_EX, 1'b0);
    chk("rst_flush", bus.flush_ID_EX, 1'b0);
    chk("rst_busy", bus.md_busy, 1'b0);
    chk("rst_done", bus.md_done, 1'b0);
    cycle();
    rst = 1'b1;
    idle_in();
    #1;
    chk("post_rst_busy", bus.md_busy, 1'b0);
    for (int k = 0; k < 40; k++) cycle();
    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      rst = 1'b1;
      bus.raddr_1_ID = 5'($urandom_range(0, 3));
      bus.raddr_2_ID = 5'($urandom_range(0, 3));
      bus.waddr_EX = 5'($urandom_range(0, 3));
      bus.uses_rs_ID = 1'($urandom_range(0, 1));
      bus.uses_rt_ID = 1'($urandom_range(0, 1));
      bus.ReadMem_EX = $urandom_range(0, 2) == 0;
      bus.md_start_ID = $urandom_range(0, 5) == 0;
      bus.md_is_div_ID = 1'($urandom_range(0, 1));
      bus.hilo_read_ID = $urandom_range(0, 3) == 0;
      bus.mem_stall = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst = 1'b0;
      end
      cycle();
    end
    rst = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS core. It generates the hold and bubble controls that freeze the PC, IF/ID and ID/EX pipeline registers, and inserts a bubble into ID/EX on a load-use hazard. It also tracks the multi-cycle HI/LO multiply/divide unit and stalls dependent instructions until it finishes. It sits beside the ID stage, reading ID and EX operand/destination information and driving the `is_hold`/flush inputs of the pipeline registers.

## Interface
- `ADDR_W`, 5: register address width.
- `MUL_CYCLES`, 4: mult/multu latency in cycles, ≥ 1.
- `DIV_CYCLES`, 32: div/divu latency in cycles, ≥ 1.
- `CNT_W`, 6: counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `raddr_1_ID` in ADDR_W: rs of the ID instruction.
- `raddr_2_ID` in ADDR_W: rt of the ID instruction.
- `uses_rs_ID` in 1: ID instruction reads rs.
- `uses_rt_ID` in 1: ID instruction reads rt.
- `ReadMem_EX` in 1: EX instruction is a load.
- `waddr_EX` in ADDR_W: destination register of the EX instruction.
- `md_start_ID` in 1: ID instruction is mult/multu/div/divu.
- `md_is_div_ID` in 1: the ID mult/div instruction is a divide.
- `hilo_read_ID` in 1: ID instruction is mfhi/mflo.
- `mem_stall` in 1: memory not ready; freeze the whole front end.
- `hold_PC` out 1: PC keeps its value.
- `hold_IF_ID` out 1: IF/ID keeps its value.
- `hold_ID_EX` out 1: ID/EX keeps its value; drives ID_EX `is_hold`.
- `flush_ID_EX` out 1: ID/EX loads a bubble (all-zero controls).
- `md_busy` out 1: mult/div in progress.
- `md_done` out 1: one-cycle pulse in the last busy cycle.

## Operation
- **Load-use hazard.** `lu` = `ReadMem_EX` & (`waddr_EX` ≠ 0) & ((`uses_rs_ID` & `raddr_1_ID` == `waddr_EX`) | (`uses_rt_ID` & `raddr_2_ID` == `waddr_EX`)).
- **Mult/div hazard.** `mdh` = `md_busy` & (`hilo_read_ID` | `md_start_ID`).
- **Stall.** `stall` = `lu` | `mdh`. A stall asserts `hold_PC`, `hold_IF_ID` and `flush_ID_EX`, and leaves `hold_ID_EX` = 0.
- **Memory stall.** `mem_stall` asserts `hold_PC`, `hold_IF_ID` and `hold_ID_EX`, and forces `flush_ID_EX` = 0. It has priority over `stall`: a frozen pipe takes no bubble.
- **FSM states.**
  - IDLE: next state is BUSY when `md_start_ID` & !`stall` & !`mem_stall`. On that edge, `cnt` ← (`md_is_div_ID` ? DIV_CYCLES : MUL_CYCLES) − 1.
  - BUSY: `cnt` decrements every edge, including during `mem_stall`. When `cnt` == 0, `md_done` = 1 and the next state is IDLE.
- **Outputs.** `md_busy` = (state == BUSY). A new `md_start_ID` during BUSY, including the done cycle, stalls and is accepted the cycle after return to IDLE.
- **Reset.** `rst` low at any time forces state IDLE and `cnt` 0, and drives every output 0 while asserted. An in-flight operation is aborted with no `md_done` pulse.

## Timing
- Hazard outputs are combinational from the current inputs and state; there is zero-cycle latency.
- A load-use stall lasts exactly 1 cycle, because the load leaves EX on the next edge.
- A mult/div accepted at edge E0 holds `md_busy` for cycles 1..N, where N is the latency. `md_done` is high in cycle N. A dependent mfhi is released in cycle N+1.
- `lu` and `mdh` together produce one merged stall with no double bubble.
- Arithmetic: the `cnt` load value is N−1, truncated to CNT_W bits. `cnt` never wraps because the decrement is gated on `cnt` ≠ 0.

## Structure
- Package `hazard_ctrl_pkg` holds:
  - the state enum `md_state_t` {MD_IDLE, MD_BUSY};
  - the `ADDR_W`/`CNT_W` defaults;
  - the localparam for the bubble (all-zero) encoding.
- One sub-module, `md_timer`: a loadable down-counter with `load`, `load_val`, `busy` and `done`, holding the FSM and `cnt`.
- The hazard compare logic stays in `hazard_ctrl`.

## Test plan
- **Load-use hit.** `ReadMem_EX`=1, `waddr_EX`=8, `raddr_1_ID`=8, `uses_rs_ID`=1 → `hold_PC`=`hold_IF_ID`=`flush_ID_EX`=1 for 1 cycle, and `hold_ID_EX`=0. The same stimulus with `waddr_EX`=0 or `uses_rs_ID`=0 → no stall.
- **Multiply then mflo.** `md_start_ID`=1, `md_is_div_ID`=0 accepted at cycle 0, mflo in ID from cycle 1 → `md_busy` high in cycles 1–4, `md_done` high in cycle 4, stall in cycles 1–4, released in cycle 5.
- **Back-to-back divide.** A second div is presented in the done cycle (cycle 32) → it stalls, is accepted in cycle 33, and `md_busy` is high in cycles 34–65.
- **Memory-stall priority.** `mem_stall`=1 with `lu`=1 → all three holds = 1 and `flush_ID_EX`=0. A divide in flight still completes at cycle 32 during the freeze.
- **Reset mid-divide.** `rst` is driven low asynchronously at cycle 10 of a divide → all outputs are 0 immediately. After `rst` releases, `md_busy`=0 and no `md_done` pulse occurs.
